trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap sequencer for the multi-cycle RV32 core. It owns the trap CSRs: mstatus, mie, mip, mtvec, mepc, mcause and mtval. It arbitrates simultaneous exception and interrupt sources by fixed priority, then runs trap entry and mret as a small FSM that redirects the fetch PC through a valid/ready handshake. It sits between the processor's step sequencer and the CSR/fetch datapath, and it replaces ad-hoc trap flag logic.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- exc_req  in  4  exception requests: [0] instr misaligned, [1] illegal instr, [2] load misaligned, [3] store misaligned
- exc_pc  in  XLEN  PC of the faulting instruction
- exc_tval  in  XLEN  faulting address/instruction for mtval
- next_pc  in  XLEN  PC of the next instruction, saved as mepc for interrupts
- irq_timer  in  1  level, mtime >= mtimecmp
- irq_ext  in  1  level, external interrupt
- instr_boundary  in  1  processor is at fetch step; interrupts may be taken
- mret  in  1  one-cycle pulse, mret executing
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  CSR write data
- redirect_ready  in  1  fetch accepts redirect_pc
- redirect_valid  out  1  redirect_pc valid
- redirect_pc  out  XLEN  new fetch PC
- busy  out  1  FSM not IDLE; processor must stall
- trap_taken  out  1  one-cycle pulse on trap entry
- mstatus, mie, mip, mtvec, mepc, mcause, mtval  out  XLEN each  CSR values

## Operation
- **States.**
  - IDLE: accepts requests.
  - TRAP_RD: redirect to handler.
  - RET_RD: redirect to mepc.
- **Priority in IDLE, highest first.**
  - Exception causes: exc_req[0] (mcause 0), [1] (2), [2] (4), [3] (6).
  - Then external interrupt (mcause 0x8000000B), then timer interrupt (0x80000007), then mret.
- **Interrupt eligibility.** An interrupt is eligible only when all hold: instr_boundary=1, mstatus[3]=1, the matching mie bit (11 or 7) = 1, the matching mip bit = 1, and exc_req=0.
- **Trap entry.** On the edge that accepts a trap:
  - mepc ← exc_pc (exception) or next_pc (interrupt), with bits [1:0] forced 0.
  - mcause ← cause.
  - mtval ← exc_tval (exception) or 0 (interrupt).
  - mstatus[7] ← mstatus[3]; mstatus[3] ← 0; mstatus[12:11] stays 2'b11.
  - State → TRAP_RD.
- **Handler address.**
  - base = {mtvec[31:2],2'b00}.
  - If mtvec[1:0]=01 and the trap is an interrupt: redirect_pc = base + 4·cause[30:0].
  - Otherwise: redirect_pc = base.
  - Sum truncated to 32 bits (wraps).
- **mret in IDLE.**
  - mstatus[3] ← mstatus[7]; mstatus[7] ← 1.
  - redirect_pc ← mepc.
  - State → RET_RD.
- **mip.** Read-only; registered each cycle. mip[7] = irq_timer, mip[11] = irq_ext, other bits 0.
- **CSR writes.** Accepted only in IDLE with no trap or mret accepted that cycle; otherwise the write is dropped.
  - 0x300 mstatus: only bits 3 and 7 writable.
  - 0x304 mie: only bits 7 and 11 writable.
  - 0x305 mtvec: bits 31:2 and 1:0 written; values 1:0 ∈ {10,11} are stored as 00.
  - 0x341 mepc: bits [1:0] forced 0.
  - 0x342 mcause, 0x343 mtval: fully writable.
  - Other addresses are ignored.
- **Non-IDLE inputs.** exc_req, interrupts and mret are ignored while not in IDLE.

## Timing
- **Reset values.** mstatus = 0x00001800; mie, mip, mtvec, mepc, mcause, mtval = 0; redirect_valid = 0; redirect_pc = 0; busy = 0; trap_taken = 0; state IDLE.
- **Reset mid-operation.** Any state goes to IDLE the next cycle; a pending redirect is discarded.
- **Latency.** A request sampled at edge N gives:
  - CSR updates visible after edge N.
  - redirect_valid = 1, busy = 1 and trap_taken = 1 (trap only) in cycle N+1.
  - trap_taken lasts exactly one cycle.
- **Handshake.**
  - redirect_valid and redirect_pc are held stable until an edge where redirect_ready = 1.
  - After that edge: redirect_valid = 0, busy = 0, state IDLE.
  - Minimum turnaround is 2 cycles, request to IDLE.
  - redirect_ready while redirect_valid = 0 is ignored.
- **Interrupt level.** An interrupt still asserted after mret (with MIE restored) is re-taken at the next eligible instr_boundary.
- **No nesting.** mstatus[3] = 0 after entry blocks nested interrupts until mret or a CSR write sets it.

## Test plan
- **Priority.** exc_req=4'b1100, exc_pc=0x100, exc_tval=0x203 → mcause=4, mepc=0x100, mtval=0x203, redirect_pc=mtvec base, trap_taken one cycle.
- **Vectored timer interrupt.** mtvec=0x00000401, mie[7]=1, mstatus[3]=1, irq_timer=1, instr_boundary=1, next_pc=0x44 → mcause=0x80000007, mepc=0x44, redirect_pc=0x41C, mstatus[3]=0, mstatus[7]=1.
- **Masking.** irq_ext=1, mie[11]=1, mstatus[3]=0 → no trap; mip[11]=1. Then a CSR write of mstatus=0x8 → trap, mcause=0x8000000B.
- **mret.** Continue from the vectored-timer-interrupt case with irq_timer=0 and an mret pulse → redirect_pc=0x44, mstatus[3]=1, mstatus[7]=1.
- **Backpressure.** Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stable, busy=1, a concurrent exc_req is ignored. Then ready=1 → IDLE next cycle.
- **Reset and collision.** Reset asserted in TRAP_RD → all outputs at reset values the next cycle. Separately, csr_we to mtvec in the same cycle as exc_req[1] → mtvec unchanged, mcause=2.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Fetch-redirect handshake: the trap sequencer offers a new fetch PC and fetch accepts it.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap CSRs plus the trap-entry / mret sequencer that redirects fetch.
// Fixed-priority arbitration picks one exception, interrupt or mret per accepted request.
module trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       exc_req,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic [XLEN-1:0]  exc_tval,
    input  logic [XLEN-1:0]  next_pc,
    input  logic             irq_timer,
    input  logic             irq_ext,
    input  logic             instr_boundary,
    input  logic             mret,
    input  logic             csr_we,
    input  logic [11:0]      csr_addr,
    input  logic [XLEN-1:0]  csr_wdata,
    trap_sequencer_if.master redirect,
    output logic             busy,
    output logic             trap_taken,
    output logic [XLEN-1:0]  mstatus,
    output logic [XLEN-1:0]  mie,
    output logic [XLEN-1:0]  mip,
    output logic [XLEN-1:0]  mtvec,
    output logic [XLEN-1:0]  mepc,
    output logic [XLEN-1:0]  mcause,
    output logic [XLEN-1:0]  mtval
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] CAUSE_IMISALIGN = 32'd0;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_LMISALIGN = 32'd4;
    localparam logic [XLEN-1:0] CAUSE_SMISALIGN = 32'd6;
    localparam logic [XLEN-1:0] CAUSE_MEI       = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_MTI       = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP_RD = 2'd1,
        RET_RD  = 2'd2
    } state_t;

    state_t          state;
    logic            st_mie;
    logic            st_mpie;
    logic            ie_mtie;
    logic            ie_meie;
    logic            ip_mtip;
    logic            ip_meip;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;

    logic            irq_ok;
    logic            take_ext;
    logic            take_tim;
    logic            is_irq;
    logic            take_trap;
    logic            take_mret;
    logic            csr_wr;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] handler;

    // Only MIE, MPIE and the hard-wired MPP=M fields exist; everything else reads zero.
    assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mie     = {20'b0, ie_meie, 3'b0, ie_mtie, 7'b0};
    assign mip     = {20'b0, ip_meip, 3'b0, ip_mtip, 7'b0};

    assign redirect.redirect_valid = valid_q;
    assign redirect.redirect_pc    = pc_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        cause     = '0;
        irq_ok    = instr_boundary && st_mie && (exc_req == 4'b0000);
        take_ext  = irq_ok && ie_meie && ip_meip;
        take_tim  = irq_ok && ie_mtie && ip_mtip;
        is_irq    = take_ext || take_tim;

        if (exc_req[0])      cause = CAUSE_IMISALIGN;
        else if (exc_req[1]) cause = CAUSE_ILLEGAL;
        else if (exc_req[2]) cause = CAUSE_LMISALIGN;
        else if (exc_req[3]) cause = CAUSE_SMISALIGN;
        else if (take_ext)   cause = CAUSE_MEI;
        else if (take_tim)   cause = CAUSE_MTI;

        take_trap = (state == IDLE) && ((exc_req != 4'b0000) || is_irq);
        take_mret = (state == IDLE) && mret && !take_trap;
        csr_wr    = (state == IDLE) && csr_we && !take_trap && !take_mret;

        // Vectored mode only applies to interrupts; the offset is 4*cause[30:0], wrapping.
        base    = {mtvec[XLEN-1:2], 2'b00};
        handler = (is_irq && (mtvec[1:0] == 2'b01)) ? base + {cause[XLEN-3:0], 2'b00} : base;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            busy       <= 1'b0;
            trap_taken <= 1'b0;
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            ie_mtie    <= 1'b0;
            ie_meie    <= 1'b0;
            ip_mtip    <= 1'b0;
            ip_meip    <= 1'b0;
            mtvec      <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
        end else begin
            trap_taken <= 1'b0;
            ip_mtip    <= irq_timer;
            ip_meip    <= irq_ext;

            case (state)
                IDLE: begin
                    if (take_trap) begin
                        mepc       <= {(is_irq ? next_pc[XLEN-1:2] : exc_pc[XLEN-1:2]), 2'b00};
                        mcause     <= cause;
                        mtval      <= is_irq ? '0 : exc_tval;
                        st_mpie    <= st_mie;
                        st_mie     <= 1'b0;
                        pc_q       <= handler;
                        valid_q    <= 1'b1;
                        busy       <= 1'b1;
                        trap_taken <= 1'b1;
                        state      <= TRAP_RD;
                    end else if (take_mret) begin
                        st_mie  <= st_mpie;
                        st_mpie <= 1'b1;
                        pc_q    <= mepc;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RET_RD;
                    end else if (csr_wr) begin
                        case (csr_addr)
                            ADDR_MSTATUS: begin
                                st_mie  <= csr_wdata[3];
                                st_mpie <= csr_wdata[7];
                            end
                            ADDR_MIE: begin
                                ie_mtie <= csr_wdata[7];
                                ie_meie <= csr_wdata[11];
                            end
                            // Reserved modes 10/11 collapse to direct mode.
                            ADDR_MTVEC:  mtvec  <= {csr_wdata[XLEN-1:2], 1'b0, (csr_wdata[1:0] == 2'b01)};
                            ADDR_MEPC:   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                            ADDR_MCAUSE: mcause <= csr_wdata;
                            ADDR_MTVAL:  mtval  <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
                TRAP_RD, RET_RD: begin
                    if (redirect.redirect_ready) begin
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a behavioural CSR/trap model predicts every cycle,
// a separate monitor pops predictions and compares them against the DUT outputs.
module tb_trap_sequencer;

    typedef struct {
        logic [31:0] mstatus, mie, mip, mtvec, mepc, mcause, mtval;
        logic        busy, valid, taken, rst;
    } snap_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } redir_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  exc_req;
    logic [31:0] exc_pc, exc_tval, next_pc;
    logic        irq_timer, irq_ext, instr_boundary, mret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        busy, trap_taken;
    logic [31:0] mstatus, mie, mip, mtvec, mepc, mcause, mtval;

    trap_sequencer_if #(.XLEN(32)) rif ();

    trap_sequencer #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .exc_req        (exc_req),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .next_pc        (next_pc),
        .irq_timer      (irq_timer),
        .irq_ext        (irq_ext),
        .instr_boundary (instr_boundary),
        .mret           (mret),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .redirect       (rif),
        .busy           (busy),
        .trap_taken     (trap_taken),
        .mstatus        (mstatus),
        .mie            (mie),
        .mip            (mip),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtval          (mtval)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    snap_t  csr_q[$];
    redir_t redir_q[$];

    // Reference machine state, kept as plain architectural fields.
    logic        m_mie_b, m_mpie, m_mtie, m_meie, m_mtip, m_meip, m_busy;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicts the effect of the coming rising edge from the inputs currently driven.
    task automatic model_edge();
        snap_t       s;
        redir_t      r;
        logic        go, irq, taken;
        logic [31:0] cause;
        go = 1'b0; irq = 1'b0; taken = 1'b0; cause = 32'h0;
        if (reset) begin
            m_mie_b = 0; m_mpie = 0; m_mtie = 0; m_meie = 0; m_busy = 0;
            m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        end else if (m_busy) begin
            if (rif.redirect_ready) m_busy = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (!go && exc_req[i]) begin go = 1; cause = 32'(2 * i); end
            if (!go && exc_req == 4'b0 && instr_boundary && m_mie_b) begin
                if (m_meie && m_meip)      begin go = 1; irq = 1; cause = 32'h8000000B; end
                else if (m_mtie && m_mtip) begin go = 1; irq = 1; cause = 32'h80000007; end
            end
            if (go) begin
                m_mepc   = (irq ? next_pc : exc_pc) & ~32'h3;
                m_mcause = cause;
                m_mtval  = irq ? 32'h0 : exc_tval;
                if (irq && (m_mtvec & 32'h3) == 32'h1)
                    r.pc = (m_mtvec & ~32'h3) + 4 * (cause & 32'h7fffffff);
                else
                    r.pc = m_mtvec & ~32'h3;
                r.taken = 1;
                redir_q.push_back(r);
                m_mpie = m_mie_b; m_mie_b = 0; m_busy = 1; taken = 1;
            end else if (mret) begin
                r.pc = m_mepc; r.taken = 0;
                redir_q.push_back(r);
                m_mie_b = m_mpie; m_mpie = 1; m_busy = 1;
            end else if (csr_we) begin
                case (csr_addr)
                    12'h300: begin m_mie_b = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: begin m_mtie = csr_wdata[7]; m_meie = csr_wdata[11]; end
                    12'h305: m_mtvec = (csr_wdata & ~32'h3) | (((csr_wdata & 32'h3) == 32'h1) ? 32'h1 : 32'h0);
                    12'h341: m_mepc = csr_wdata & ~32'h3;
                    12'h342: m_mcause = csr_wdata;
                    12'h343: m_mtval = csr_wdata;
                    default: ;
                endcase
            end
        end
        m_mtip = reset ? 1'b0 : irq_timer;
        m_meip = reset ? 1'b0 : irq_ext;

        s.mstatus = 32'h1800 | (m_mie_b ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
        s.mie     = (m_mtie ? 32'h80 : 32'h0) | (m_meie ? 32'h800 : 32'h0);
        s.mip     = (m_mtip ? 32'h80 : 32'h0) | (m_meip ? 32'h800 : 32'h0);
        s.mtvec   = m_mtvec;  s.mepc = m_mepc;  s.mcause = m_mcause;  s.mtval = m_mtval;
        s.busy    = m_busy;   s.valid = m_busy; s.taken = taken;      s.rst = reset;
        csr_q.push_back(s);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        exc_req = 4'b0; mret = 0; csr_we = 0; instr_boundary = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 0;
    endtask

    // Monitor: pops per-cycle CSR predictions and per-transaction redirect predictions.
    logic   prev_valid = 1'b0;
    redir_t cur;
    initial begin
        snap_t s;
        cur.pc = 32'h0; cur.taken = 1'b0;
        forever begin
            @(negedge clk);
            if (csr_q.size() != 0) begin
                s = csr_q.pop_front();
                check("mstatus", mstatus, s.mstatus);
                check("mie", mie, s.mie);
                check("mip", mip, s.mip);
                check("mtvec", mtvec, s.mtvec);
                check("mepc", mepc, s.mepc);
                check("mcause", mcause, s.mcause);
                check("mtval", mtval, s.mtval);
                check("busy", {31'b0, busy}, {31'b0, s.busy});
                check("redirect_valid", {31'b0, rif.redirect_valid}, {31'b0, s.valid});
                check("trap_taken", {31'b0, trap_taken}, {31'b0, s.taken});
                if (s.rst) check("reset_redirect_pc", rif.redirect_pc, 32'h0);
            end
            if (rif.redirect_valid && !prev_valid) begin
                if (redir_q.size() == 0) begin
                    check("spurious_redirect_valid", {31'b0, rif.redirect_valid}, 32'h0);
                end else begin
                    cur = redir_q.pop_front();
                    check("redirect_pc", rif.redirect_pc, cur.pc);
                    check("redirect_trap_taken", {31'b0, trap_taken}, {31'b0, cur.taken});
                end
            end else if (rif.redirect_valid) begin
                check("redirect_pc_hold", rif.redirect_pc, cur.pc);
            end
            prev_valid = rif.redirect_valid;
        end
    end

    logic [11:0] addrs [8];

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h340, 12'h344};
        reset = 1; clr(); irq_timer = 0; irq_ext = 0; rif.redirect_ready = 0;
        exc_pc = 0; exc_tval = 0; next_pc = 0; csr_addr = 0; csr_wdata = 0;
        step(); step();
        reset = 0; step();

        // Priority: misaligned load beats misaligned store.
        csr_write(12'h305, 32'h2000);
        exc_req = 4'b1100; exc_pc = 32'h100; exc_tval = 32'h203; step();
        exc_req = 4'b0; step();
        rif.redirect_ready = 1; step(); step();

        // Vectored timer interrupt.
        csr_write(12'h305, 32'h401);
        csr_write(12'h304, 32'h80);
        irq_timer = 1;
        csr_write(12'h300, 32'h8);
        instr_boundary = 1; next_pc = 32'h44; rif.redirect_ready = 0; step();
        instr_boundary = 0; step();
        rif.redirect_ready = 1; step();

        // mret back to the interrupted PC.
        irq_timer = 0; step();
        mret = 1; step();
        mret = 0; step(); step();

        // Masking, then enabling through a CSR write.
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h0);
        irq_ext = 1; instr_boundary = 1;
        step(); step(); step();
        csr_write(12'h300, 32'h8);
        step();
        irq_ext = 0; instr_boundary = 0; step(); step();

        // Backpressure with concurrent requests that must be ignored.
        rif.redirect_ready = 0; exc_req = 4'b0001; exc_pc = 32'h303; exc_tval = 32'h55; step();
        for (int i = 0; i < 5; i++) begin
            exc_req = 4'b0010; mret = 1; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'hdead0000;
            step();
        end
        clr(); rif.redirect_ready = 1; step(); step();

        // Reset while redirecting to a trap handler.
        rif.redirect_ready = 0; exc_req = 4'b0100; exc_pc = 32'h500; step();
        exc_req = 4'b0; reset = 1; step();
        reset = 0; step();

        // CSR write collides with an exception: the write is dropped.
        csr_write(12'h305, 32'h1000);
        csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h999; exc_req = 4'b0010; exc_pc = 32'h77;
        step();
        clr(); rif.redirect_ready = 1; step(); step();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            exc_req   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            exc_pc    = $urandom; exc_tval = $urandom; next_pc = $urandom;
            if ($urandom_range(0, 15) == 0) irq_timer = ~irq_timer;
            if ($urandom_range(0, 15) == 0) irq_ext = ~irq_ext;
            instr_boundary     = ($urandom_range(0, 2) == 0);
            mret               = ($urandom_range(0, 9) == 0);
            csr_we             = ($urandom_range(0, 3) == 0);
            csr_addr           = addrs[$urandom_range(0, 7)];
            csr_wdata          = $urandom;
            rif.redirect_ready = ($urandom_range(0, 2) != 0);
            reset              = ($urandom_range(0, 299) == 0);
            step();
        end

        clr(); reset = 0; rif.redirect_ready = 1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        #1;
        check("csr_queue_drained", csr_q.size(), 32'h0);
        check("redirect_queue_drained", redir_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
